// File: rtl/tiger_checkpoint_ctrl.sv
// Purpose: power-aware checkpoint/rollback sequencer driving the TigerMIPS core power/snapshot inputs.
// Latency: supply inputs take effect on outputs at the 3rd rising edge (2 sync flops + state register).
// Backpressure: none; the core cannot stall this block, and all outputs are Moore decodes of the state.
// Ports: clk, reset (async active-low); vddOk/vddWarn (async supply monitors);
//        poweroff, poweron[1:0], checkpoint, checkpointing, checkpointdone, zstall (core controls);
//        ckptValid, ckptCount[15:0] (committed-checkpoint status).
module tiger_checkpoint_ctrl #(
   parameter int unsigned CKPT_INTERVAL  = 1024,
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter int unsigned SAVE_CYCLES    = 32,
   parameter int unsigned RESTORE_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vddOk,
   input  logic        vddWarn,
   output logic        poweroff,
   output logic [1:0]  poweron,
   output logic        checkpoint,
   output logic        checkpointing,
   output logic        checkpointdone,
   output logic        zstall,
   output logic        ckptValid,
   output logic [15:0] ckptCount
);

   typedef enum logic [2:0] {OFF, RESTORE, RUN, DRAIN, SAVE, COMMIT, DOWN} stateT;

   stateT       state, stateNext;
   logic [31:0] cnt, cntNext;
   logic [1:0]  mode, modeNext;
   logic        validNext;
   logic [15:0] ckptCntReg, countNext;
   logic [1:0]  okSync, warnSync;
   logic        okS, warnS, leave;

   assign okS       = okSync[1];
   assign warnS     = warnSync[1];
   assign ckptCount = ckptCntReg;

   // Any live state (not COMMIT) is abandoned on a warning or a lost supply.
   assign leave = warnS || !okS;

   // State register, counters, checkpoint status and input synchronisers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= OFF;
         cnt        <= '0;
         mode       <= 2'b00;
         ckptValid  <= 1'b0;
         ckptCntReg <= 16'h0000;
         okSync     <= 2'b00;
         warnSync   <= 2'b00;
      end else begin
         state      <= stateNext;
         cnt        <= cntNext;
         mode       <= modeNext;
         ckptValid  <= validNext;
         ckptCntReg <= countNext;
         okSync     <= {okSync[0], vddOk};
         warnSync   <= {warnSync[0], vddWarn};
      end
   end

   // Next-state logic. The timed states share one counter that restarts at 0 on entry.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      modeNext  = mode;
      validNext = ckptValid;
      countNext = ckptCntReg;
      case (state)
         OFF: begin
            if (okS && !warnS) begin
               stateNext = RESTORE;
               cntNext   = '0;
               modeNext  = ckptValid ? 2'b10 : 2'b01;
            end
         end
         RESTORE: begin
            if (leave) stateNext = DOWN;
            else if (cnt == RESTORE_CYCLES - 1) begin
               stateNext = RUN;
               cntNext   = '0;
            end else cntNext = cnt + 32'd1;
         end
         RUN: begin
            if (leave) stateNext = DOWN;
            else if (cnt == CKPT_INTERVAL - 1) begin
               stateNext = DRAIN;
               cntNext   = '0;
            end else cntNext = cnt + 32'd1;
         end
         DRAIN: begin
            if (leave) stateNext = DOWN;
            else if (cnt == DRAIN_CYCLES - 1) begin
               stateNext = SAVE;
               cntNext   = '0;
            end else cntNext = cnt + 32'd1;
         end
         SAVE: begin
            // A warning here aborts the snapshot; the previous checkpoint remains the valid one.
            if (leave) stateNext = DOWN;
            else if (cnt == SAVE_CYCLES - 1) begin
               stateNext = COMMIT;
               cntNext   = '0;
            end else cntNext = cnt + 32'd1;
         end
         COMMIT: begin
            // The commit always completes; a pending warning is seen next cycle in RUN.
            validNext = 1'b1;
            countNext = ckptCntReg + 16'd1;
            cntNext   = '0;
            stateNext = okS ? RUN : DOWN;
         end
         DOWN: begin
            if (!okS) stateNext = OFF;
         end
         default: stateNext = OFF;
      endcase
   end

   // Moore output decode.
   always_comb begin
      poweroff       = 1'b0;
      poweron        = 2'b00;
      checkpoint     = 1'b0;
      checkpointing  = 1'b0;
      checkpointdone = 1'b0;
      zstall         = 1'b1;
      case (state)
         OFF, DOWN: poweroff = 1'b1;
         RESTORE:   poweron = mode;
         RUN:       zstall = 1'b0;
         DRAIN:     ;
         SAVE: begin
            checkpoint    = 1'b1;
            checkpointing = 1'b1;
         end
         COMMIT:    checkpointdone = 1'b1;
         default:   poweroff = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_tiger_checkpoint_ctrl.sv
// Purpose: self-checking bench for tiger_checkpoint_ctrl using a cycle-indexed expectation queue.
// Latency: expectations are tagged with the absolute cycle in which the output vector must appear.
// Backpressure: none; stimulus is driven 1 time unit after each rising edge, outputs sampled on falling edges.
module tb_tiger_checkpoint_ctrl;

   logic        clk = 1'b0;
   logic        reset, vddOk, vddWarn;
   logic        poweroff, checkpoint, checkpointing, checkpointdone, zstall, ckptValid;
   logic [1:0]  poweron;
   logic [15:0] ckptCount;
   logic [23:0] obsV;

   tiger_checkpoint_ctrl #(
      .CKPT_INTERVAL (8),
      .DRAIN_CYCLES  (2),
      .SAVE_CYCLES   (4),
      .RESTORE_CYCLES(3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .vddOk         (vddOk),
      .vddWarn       (vddWarn),
      .poweroff      (poweroff),
      .poweron       (poweron),
      .checkpoint    (checkpoint),
      .checkpointing (checkpointing),
      .checkpointdone(checkpointdone),
      .zstall        (zstall),
      .ckptValid     (ckptValid),
      .ckptCount     (ckptCount)
   );

   always #5 clk = ~clk;

   assign obsV = {poweroff, poweron, checkpoint, checkpointing, checkpointdone, zstall, ckptValid, ckptCount};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      string       tag;
      logic [23:0] v;
   } expT;

   expT sb[$];
   int  nTests = 0;
   int  nFail  = 0;
   int  b      = 0;

   task automatic checkEq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      nTests++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Expected output vectors, one per state as seen by the core.
   function automatic logic [23:0] vOff(input bit v, input logic [15:0] c);
      return {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, v, c};
   endfunction
   function automatic logic [23:0] vRs(input logic [1:0] m, input bit v, input logic [15:0] c);
      return {1'b0, m, 1'b0, 1'b0, 1'b0, 1'b1, v, c};
   endfunction
   function automatic logic [23:0] vRun(input bit v, input logic [15:0] c);
      return {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, v, c};
   endfunction
   function automatic logic [23:0] vDr(input bit v, input logic [15:0] c);
      return {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, v, c};
   endfunction
   function automatic logic [23:0] vSv(input bit v, input logic [15:0] c);
      return {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, v, c};
   endfunction
   function automatic logic [23:0] vCm(input bit v, input logic [15:0] c);
      return {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, v, c};
   endfunction

   task automatic expRange(input int from, input int to, input string tag, input logic [23:0] v);
      for (int i = from; i <= to; i++) sb.push_back('{b + i, tag, v});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitTo(input int n);
      while (cyc < b + n) tick();
   endtask

   // Monitor: compare every expectation due in this cycle.
   always @(negedge clk) begin
      expT e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         checkEq($sformatf("%s@%0d", e.tag, e.at - b), obsV, e.v);
      end
   end

   initial begin
      reset   = 1'b0;
      vddOk   = 1'b0;
      vddWarn = 1'b0;
      tick();
      tick();
      b = cyc;
      expRange(0, 0, "rstVal", vOff(1'b0, 16'd0));
      tick();

      // Cold start: reset released and supply good in cycle 0.
      b       = cyc;
      reset   = 1'b1;
      vddOk   = 1'b1;
      expRange(0, 2, "off", vOff(1'b0, 16'd0));
      expRange(3, 5, "coldRestore", vRs(2'b01, 1'b0, 16'd0));
      expRange(6, 13, "run", vRun(1'b0, 16'd0));
      expRange(14, 15, "drain", vDr(1'b0, 16'd0));
      expRange(16, 19, "save", vSv(1'b0, 16'd0));
      expRange(20, 20, "commit", vCm(1'b0, 16'd0));
      expRange(21, 23, "runAfterCommit", vRun(1'b1, 16'd1));

      // Rollback: warning mid-RUN, then supply cycles off and back on.
      waitTo(24);
      vddWarn = 1'b1;
      expRange(24, 26, "runPreWarn", vRun(1'b1, 16'd1));
      expRange(27, 29, "warnDown", vOff(1'b1, 16'd1));
      waitTo(30);
      vddWarn = 1'b0;
      vddOk   = 1'b0;
      expRange(30, 32, "down", vOff(1'b1, 16'd1));
      expRange(33, 34, "off", vOff(1'b1, 16'd1));
      waitTo(35);
      vddOk = 1'b1;
      expRange(35, 37, "off", vOff(1'b1, 16'd1));
      expRange(38, 40, "rollback", vRs(2'b10, 1'b1, 16'd1));
      expRange(41, 48, "run", vRun(1'b1, 16'd1));
      expRange(49, 50, "drain", vDr(1'b1, 16'd1));
      expRange(51, 51, "save", vSv(1'b1, 16'd1));

      // Abort: warning raised on the 2nd SAVE cycle, lands on the last one.
      waitTo(52);
      vddWarn = 1'b1;
      expRange(52, 54, "save", vSv(1'b1, 16'd1));
      expRange(55, 56, "abortDown", vOff(1'b1, 16'd1));
      waitTo(57);
      vddWarn = 1'b0;
      vddOk   = 1'b0;
      expRange(57, 59, "down", vOff(1'b1, 16'd1));
      expRange(60, 60, "off", vOff(1'b1, 16'd1));
      waitTo(61);
      vddOk = 1'b1;
      expRange(61, 63, "off", vOff(1'b1, 16'd1));
      expRange(64, 66, "rollback2", vRs(2'b10, 1'b1, 16'd1));
      expRange(67, 71, "run", vRun(1'b1, 16'd1));

      // Synced warning present on the final RUN cycle: DOWN wins over DRAIN.
      waitTo(72);
      vddWarn = 1'b1;
      expRange(72, 74, "lastRun", vRun(1'b1, 16'd1));
      expRange(75, 77, "simulDown", vOff(1'b1, 16'd1));
      waitTo(78);
      vddWarn = 1'b0;
      vddOk   = 1'b0;
      expRange(78, 80, "down", vOff(1'b1, 16'd1));
      expRange(81, 81, "off", vOff(1'b1, 16'd1));
      waitTo(82);
      vddOk = 1'b1;
      expRange(82, 84, "off", vOff(1'b1, 16'd1));
      expRange(85, 87, "rollback3", vRs(2'b10, 1'b1, 16'd1));
      expRange(88, 88, "run", vRun(1'b1, 16'd1));

      // Wrap: preload the count to 0xFFFF and let one commit complete.
      waitTo(89);
      force dut.ckptCntReg = 16'hFFFF;
      #1;
      release dut.ckptCntReg;
      expRange(89, 95, "runPreWrap", vRun(1'b1, 16'hFFFF));
      expRange(96, 97, "drain", vDr(1'b1, 16'hFFFF));
      expRange(98, 101, "save", vSv(1'b1, 16'hFFFF));
      expRange(102, 102, "commitWrap", vCm(1'b1, 16'hFFFF));
      expRange(103, 110, "wrapRun", vRun(1'b1, 16'h0000));
      expRange(111, 112, "drain", vDr(1'b1, 16'h0000));
      expRange(113, 113, "save", vSv(1'b1, 16'h0000));

      // Asynchronous reset in the middle of SAVE.
      waitTo(114);
      expRange(114, 115, "asyncRst", vOff(1'b0, 16'h0000));
      #1;
      reset = 1'b0;
      waitTo(116);
      checkEq("sbEmpty", 24'(sb.size()), 24'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
